// File: rtl/cpu.sv
// Multi-cycle hardwired CPU core for a small Sigma-7-style 32-bit instruction subset.
// Bit 0 is the MSB of every word; addresses are 17-bit word addresses.
module cpu #(
  parameter logic [16:0] RESET_ADDR = 17'h00000,
  parameter int unsigned UROM_DEPTH = 256
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         active,
  input  logic [0:31]  memory_data_in,
  output logic [15:31] memory_address,
  output logic [0:31]  memory_data_out,
  output logic [0:3]   mem_write_en
);

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StInd   = 2'd1,
    StExec  = 2'd2,
    StHalt  = 2'd3
  } state_e;

  localparam logic [1:7] OpAi   = 7'h20;
  localparam logic [1:7] OpLi   = 7'h22;
  localparam logic [1:7] OpWait = 7'h2E;
  localparam logic [1:7] OpAw   = 7'h30;
  localparam logic [1:7] OpCw   = 7'h31;
  localparam logic [1:7] OpLw   = 7'h32;
  localparam logic [1:7] OpStw  = 7'h35;
  localparam logic [1:7] OpBcr  = 7'h68;
  localparam logic [1:7] OpBcs  = 7'h69;

  logic [15:31] q;
  logic [0:31]  p;
  logic [0:31]  c;
  logic [1:7]   o;
  logic [1:4]   cc;
  logic         trap;
  logic         ende;
  logic [0:31]  regs [16];

  logic [15:31] ind_base_q;
  logic         ind_used_q;
  state_e       state_d;

  logic [15:31] ea;
  logic [0:31]  r_val;
  logic [0:31]  imm;
  logic [0:31]  src;
  logic [32:0]  sum;
  logic         wr_en;
  logic [0:31]  wr_val;
  logic [1:4]   cc_d;
  logic         br_take;
  logic         op_legal;
  logic         unused_bits;

  function automatic logic is_memref(input logic [1:7] op);
    return op inside {OpAw, OpCw, OpLw, OpStw, OpBcr, OpBcs};
  endfunction

  assign p        = {13'd0, q, 2'b00};
  assign op_legal = is_memref(o) || (o inside {OpAi, OpLi, OpWait});

  // Sequencer: holds the FSM state register probed as seq.pc.
  if (1) begin : seq
    state_e pc;
    // State register; frozen while the core is stalled.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pc <= StFetch;
      end else if (active) begin
        pc <= state_d;
      end
    end
  end

  // Reserved control store; loaded externally, not consulted by the hardwired control.
  if (1) begin : uc_rom
    logic [0:31] memory [0:UROM_DEPTH-1];
  end

  assign unused_bits = ^{c[0:7], p, uc_rom.memory[0]};

  // Execute datapath: effective address, ALU result, condition codes, branch decision.
  always_comb begin
    r_val   = regs[c[8:11]];
    imm     = {{12{c[12]}}, c[12:31]};
    ea      = (ind_used_q ? ind_base_q : c[15:31]) +
              ((c[12:14] != 3'd0) ? regs[{1'b0, c[12:14]}][15:31] : 17'd0);
    src     = (o == OpAi) ? imm : memory_data_in;
    sum     = {1'b0, r_val} + {1'b0, src};
    wr_en   = 1'b0;
    wr_val  = sum[31:0];
    cc_d    = cc;
    br_take = 1'b0;
    case (o)
      OpLi: begin
        wr_en  = 1'b1;
        wr_val = imm;
        cc_d   = {2'b00, (imm != 32'd0) && !imm[0], imm[0]};
      end
      OpLw: begin
        wr_en  = 1'b1;
        wr_val = memory_data_in;
        cc_d   = {2'b00, (memory_data_in != 32'd0) && !memory_data_in[0], memory_data_in[0]};
      end
      OpAi, OpAw: begin
        wr_en = 1'b1;
        // Overflow: operands share a sign that the result does not.
        cc_d  = {sum[32], (r_val[0] == src[0]) && (sum[31] != r_val[0]),
                 (sum[31:0] != 32'd0) && !sum[31], sum[31]};
      end
      OpCw: begin
        cc_d[3] = $signed(r_val) > $signed(memory_data_in);
        cc_d[4] = $signed(r_val) < $signed(memory_data_in);
      end
      OpBcr:   br_take = (c[8:11] & cc) == 4'd0;
      OpBcs:   br_take = (c[8:11] & cc) != 4'd0;
      default: ;
    endcase
  end

  // Next state, memory address mux and per-cycle strobes.
  always_comb begin
    state_d         = seq.pc;
    memory_address  = q;
    memory_data_out = '0;
    mem_write_en    = '0;
    ende            = 1'b0;
    case (seq.pc)
      StFetch: begin
        state_d = (memory_data_in[0] && is_memref(memory_data_in[1:7])) ? StInd : StExec;
      end
      StInd: begin
        memory_address = c[15:31];
        state_d        = StExec;
      end
      StExec: begin
        memory_address = ea;
        state_d        = (!op_legal || (o == OpWait)) ? StHalt : StFetch;
        ende           = active && op_legal;
        if (o == OpStw) begin
          memory_data_out = r_val;
          mem_write_en    = {4{active}};
        end
      end
      default: state_d = StHalt;
    endcase
  end

  // Architectural state update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q          <= RESET_ADDR;
      c          <= '0;
      o          <= '0;
      cc         <= '0;
      trap       <= 1'b0;
      ind_base_q <= '0;
      ind_used_q <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (active) begin
      case (seq.pc)
        StFetch: begin
          c          <= memory_data_in;
          o          <= memory_data_in[1:7];
          q          <= q + 17'd1;
          ind_used_q <= 1'b0;
        end
        StInd: begin
          ind_base_q <= memory_data_in[15:31];
          ind_used_q <= 1'b1;
        end
        StExec: begin
          if (!op_legal) begin
            trap <= 1'b1;
          end else begin
            if (wr_en) regs[c[8:11]] <= wr_val;
            cc <= cc_d;
            if (br_take) q <= ea;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed programs plus random straight-line programs checked against an
// instruction-level reference model.
module tb_cpu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        active = 1'b1;
  logic [31:0] memory_data_in;
  logic [16:0] memory_address;
  logic [31:0] memory_data_out;
  logic [3:0]  mem_write_en;

  logic [31:0] mem [0:131071];
  logic [31:0] mm  [0:131071];

  int checks = 0;
  int errors = 0;
  int n_ende;
  int n_wr;

  logic [31:0] m_regs [16];
  logic [3:0]  m_cc;
  logic [16:0] m_q;
  logic        m_trap;
  logic [16:0] wq [$];

  cpu dut (
    .clock           (clock),
    .reset           (reset),
    .active          (active),
    .memory_data_in  (memory_data_in),
    .memory_address  (memory_address),
    .memory_data_out (memory_data_out),
    .mem_write_en    (mem_write_en)
  );

  always #5 clock = ~clock;

  assign memory_data_in = mem[memory_address];

  // Byte-lane write; mem_write_en[3] is lane 0 (most significant byte).
  always @(posedge clock) begin
    for (int l = 0; l < 4; l++) begin
      if (mem_write_en[3-l]) mem[memory_address][31-8*l -: 8] = memory_data_out[31-8*l -: 8];
    end
  end

  always @(negedge clock or posedge reset) begin
    if (reset) begin
      n_ende = 0;
      n_wr   = 0;
    end else begin
      if (dut.ende) n_ende = n_ende + 1;
      if (mem_write_en != 4'd0) n_wr = n_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 131072; a++) begin
      mem[a] = 32'd0;
      mm[a]  = 32'd0;
    end
  endtask

  task automatic put(input logic [16:0] a, input logic [31:0] v);
    mem[a] = v;
    mm[a]  = v;
  endtask

  function automatic logic [31:0] ins(input logic i, input logic [6:0] op, input logic [3:0] r,
                                      input logic [2:0] x, input logic [16:0] a);
    return {i, op, r, x, a};
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    active = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic load_t1();
    clear_mem();
    put(17'h0, 32'h22100005);
    put(17'h1, 32'h201FFFFE);
    put(17'h2, 32'h35100100);
    put(17'h3, 32'h2E000000);
  endtask

  // Instruction-level reference: executes from mm until WAIT or an illegal opcode.
  task automatic model_run(output int cyc, output int nende, output int nst);
    logic [31:0] w, imm, a, b, res;
    logic [6:0]  op;
    logic [3:0]  r;
    logic [2:0]  x;
    logic [16:0] base, ea;
    longint      us, ss;
    bit          mr, legal, done;
    cyc = 0; nende = 0; nst = 0; done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      w = mm[m_q];
      m_q = m_q + 17'd1;
      op = w[30:24]; r = w[23:20]; x = w[19:17];
      imm = {{12{w[19]}}, w[19:0]};
      mr = op inside {7'h30, 7'h31, 7'h32, 7'h35, 7'h68, 7'h69};
      legal = mr || (op inside {7'h20, 7'h22, 7'h2E});
      cyc += 2;
      if (!legal) begin
        m_trap = 1'b1;
        done = 1'b1;
      end else begin
        base = w[16:0];
        if (w[31] && mr) begin
          base = mm[w[16:0]][16:0];
          cyc += 1;
        end
        ea = base + ((x != 3'd0) ? m_regs[x][16:0] : 17'd0);
        nende++;
        a = m_regs[r];
        b = (op == 7'h20) ? imm : mm[ea];
        us = longint'(a) + longint'(b);
        ss = longint'($signed(a)) + longint'($signed(b));
        res = a + b;
        case (op)
          7'h20, 7'h30: begin
            m_regs[r] = res;
            m_cc = {us > 64'sd4294967295, ss > 64'sd2147483647 || ss < -64'sd2147483648,
                    $signed(res) > 0, $signed(res) < 0};
          end
          7'h22: begin
            m_regs[r] = imm;
            m_cc = {2'b00, $signed(imm) > 0, $signed(imm) < 0};
          end
          7'h32: begin
            m_regs[r] = b;
            m_cc = {2'b00, $signed(b) > 0, $signed(b) < 0};
          end
          7'h31: m_cc[1:0] = {$signed(a) > $signed(b), $signed(a) < $signed(b)};
          7'h35: begin
            mm[ea] = a;
            wq.push_back(ea);
            nst++;
          end
          7'h68: if ((r & m_cc) == 4'd0) m_q = ea;
          7'h69: if ((r & m_cc) != 4'd0) m_q = ea;
          default: done = 1'b1;
        endcase
      end
    end
  endtask

  logic [6:0] ops [6] = '{7'h22, 7'h20, 7'h32, 7'h30, 7'h31, 7'h35};

  initial begin
    int cyc, nende, nst;
    logic [31:0] sum;

    // Reset state and the basic four-instruction program.
    load_t1();
    reset = 1'b1;
    tick(2);
    chk("rst_q", 32'(dut.q), 32'h0);
    chk("rst_c", dut.c, 32'h0);
    chk("rst_o", 32'(dut.o), 32'h0);
    chk("rst_cc", 32'(dut.cc), 32'h0);
    chk("rst_trap", 32'(dut.trap), 32'h0);
    chk("rst_ende", 32'(dut.ende), 32'h0);
    chk("rst_state", 32'(dut.seq.pc), 32'd0);
    chk("rst_we", 32'(mem_write_en), 32'h0);
    chk("rst_dout", memory_data_out, 32'h0);
    sum = 32'd0;
    for (int i = 0; i < 16; i++) sum = sum | dut.regs[i];
    chk("rst_regs", sum, 32'h0);
    reset = 1'b0;
    tick(2);
    chk("t1_r1_li", dut.regs[1], 32'd5);
    tick(2);
    chk("t1_r1_ai", dut.regs[1], 32'd3);
    chk("t1_cc34", 32'({dut.cc[3], dut.cc[4]}), 32'b10);
    tick(1);
    chk("t1_stw_we", 32'(mem_write_en), 32'hF);
    chk("t1_stw_addr", 32'(memory_address), 32'h100);
    tick(3);
    chk("t1_mem100", mem[17'h100], 32'd3);
    chk("t1_wr_cycles", 32'(n_wr), 32'd1);
    chk("t1_o_wait", 32'(dut.o), 32'h2E);
    chk("t1_p", (dut.p >> 2) - 32'd1, 32'd3);
    chk("t1_ende", 32'(n_ende), 32'd4);
    chk("t1_halt", 32'(dut.seq.pc), 32'd3);

    // Illegal opcode traps after one fetch.
    clear_mem();
    do_reset();
    tick(1);
    chk("t2_trap_early", 32'(dut.trap), 32'h0);
    tick(1);
    chk("t2_trap", 32'(dut.trap), 32'h1);
    chk("t2_q", 32'(dut.q), 32'h1);
    chk("t2_c", dut.c, 32'h0);
    chk("t2_state", 32'(dut.seq.pc), 32'd3);
    tick(2);
    chk("t2_ende", 32'(n_ende), 32'd0);
    chk("t2_wr", 32'(n_wr), 32'd0);

    // Indexed load.
    clear_mem();
    put(17'h0, 32'h22200001);
    put(17'h1, ins(1'b0, 7'h32, 4'd3, 3'd2, 17'h0FF));
    put(17'h2, 32'h2E000000);
    put(17'h100, 32'h80000000);
    do_reset();
    tick(6);
    chk("t3_r3", dut.regs[3], 32'h80000000);
    chk("t3_cc", 32'(dut.cc), 32'b0001);

    // Indirect load.
    clear_mem();
    put(17'h0, ins(1'b1, 7'h32, 4'd4, 3'd0, 17'h200));
    put(17'h1, 32'h2E000000);
    put(17'h200, 32'h00000100);
    put(17'h100, 32'h7);
    do_reset();
    tick(1);
    chk("t4_ind_state", 32'(dut.seq.pc), 32'd1);
    tick(1);
    chk("t4_exec_state", 32'(dut.seq.pc), 32'd2);
    tick(1);
    chk("t4_r4", dut.regs[4], 32'h7);
    chk("t4_fetch_state", 32'(dut.seq.pc), 32'd0);

    // Compare and branch.
    clear_mem();
    put(17'h0, 32'h22100003);
    put(17'h1, ins(1'b0, 7'h31, 4'd1, 3'd0, 17'h100));
    put(17'h2, ins(1'b0, 7'h69, 4'd1, 3'd0, 17'h010));
    put(17'h10, ins(1'b0, 7'h68, 4'd1, 3'd0, 17'h020));
    put(17'h11, 32'h2E000000);
    put(17'h100, 32'd5);
    do_reset();
    tick(4);
    chk("t5_cw_cc", 32'(dut.cc), 32'b0001);
    tick(2);
    chk("t5_bcs_q", 32'(dut.q), 32'h10);
    tick(2);
    chk("t5_bcr_q", 32'(dut.q), 32'h11);
    tick(2);
    chk("t5_halt", 32'(dut.seq.pc), 32'd3);

    // Stall for five cycles just before the store is fetched.
    load_t1();
    do_reset();
    tick(4);
    #1 active = 1'b0;
    tick(5);
    chk("t6_q", 32'(dut.q), 32'h2);
    chk("t6_c", dut.c, 32'h201FFFFE);
    chk("t6_state", 32'(dut.seq.pc), 32'd0);
    chk("t6_wr", 32'(n_wr), 32'd0);
    #1 active = 1'b1;
    tick(4);
    chk("t6_mem100", mem[17'h100], 32'd3);
    chk("t6_ende", 32'(n_ende), 32'd4);

    // Reset during the store's execute cycle drops the write.
    load_t1();
    do_reset();
    tick(5);
    chk("t7_we_before", 32'(mem_write_en), 32'hF);
    #1 reset = 1'b1;
    #1 chk("t7_we_reset", 32'(mem_write_en), 32'h0);
    tick(1);
    chk("t7_mem100", mem[17'h100], 32'd0);
    chk("t7_q", 32'(dut.q), 32'h0);
    reset = 1'b0;

    // Random straight-line programs against the reference model.
    for (int t = 0; t < 6; t++) begin
      clear_mem();
      wq.delete();
      for (int k = 0; k < 4; k++) begin
        put(17'(k), ins(1'b0, 7'h22, 4'($urandom_range(1, 15)), 3'($urandom), 17'($urandom)));
      end
      for (int k = 4; k < 14; k++) begin
        put(17'(k), ins(1'($urandom_range(0, 3) == 0), ops[$urandom_range(0, 5)],
                        4'($urandom), ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0,
                        17'h100 + 17'($urandom_range(0, 63))));
      end
      put(17'd14, 32'h2E000000);
      for (int a = 17'h100; a < 17'h140; a++) put(17'(a), $urandom);
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      m_cc = 4'd0; m_q = 17'd0; m_trap = 1'b0;
      model_run(cyc, nende, nst);
      do_reset();
      tick(cyc);
      chk($sformatf("r%0d_state", t), 32'(dut.seq.pc), 32'd3);
      chk($sformatf("r%0d_trap", t), 32'(dut.trap), 32'(m_trap));
      chk($sformatf("r%0d_q", t), 32'(dut.q), 32'(m_q));
      chk($sformatf("r%0d_cc", t), 32'(dut.cc), 32'(m_cc));
      for (int i = 0; i < 16; i++) chk($sformatf("r%0d_reg%0d", t, i), dut.regs[i], m_regs[i]);
      tick(2);
      chk($sformatf("r%0d_ende", t), 32'(n_ende), 32'(nende));
      chk($sformatf("r%0d_writes", t), 32'(n_wr), 32'(nst));
      foreach (wq[j]) chk($sformatf("r%0d_mem_%h", t, wq[j]), mem[wq[j]], mm[wq[j]]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
